// File: rtl/adv7513_reg_dump.sv
// Walks an ADV7513 register address range through an external read engine
// and queues {address, data} results in a first-word-fall-through FIFO.
module adv7513_reg_dump #(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] first_addr,
  input  logic [7:0] last_addr,
  output logic       busy,
  output logic       dump_done,
  output logic       timeout_err,
  output logic       range_err,
  output logic       rd_start,
  output logic [7:0] rd_addr,
  input  logic       rd_done,
  input  logic [7:0] rd_data,
  output logic       out_valid,
  output logic [7:0] out_addr,
  output logic [7:0] out_data,
  input  logic       out_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PUSH, FINISH} state_t;

  state_t          state_q, state_d;
  logic [7:0]      cur_q, cur_d;
  logic [7:0]      last_q, last_d;
  logic [7:0]      data_q, data_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            timeout_err_q, timeout_err_d;
  logic            range_err_q, range_err_d;

  logic [15:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            fifo_full, fifo_empty, push, pop;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q         <= '0;
      last_q        <= '0;
      data_q        <= '0;
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
      range_err_q   <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      cur_q         <= cur_d;
      last_q        <= last_d;
      data_q        <= data_d;
      timer_q       <= timer_d;
      timeout_err_q <= timeout_err_d;
      range_err_q   <= range_err_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cur_q, data_q};
  end

  // Full is judged on the registered count, so a pop only frees the slot next cycle.
  always_comb begin
    fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
    fifo_empty = (count_q == '0);
    push       = (state_q == PUSH) && !fifo_full;
    pop        = !fifo_empty && out_ready;
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    last_d        = last_q;
    data_d        = data_q;
    timer_d       = timer_q;
    timeout_err_d = timeout_err_q;
    range_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) begin
          cur_d         = first_addr;
          last_d        = last_addr;
          timeout_err_d = 1'b0;
          if (first_addr > last_addr) begin
            range_err_d = 1'b1;
            state_d     = FINISH;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (rd_done) begin
          data_d  = rd_data;
          state_d = PUSH;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = FINISH;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      PUSH: begin
        // Comparing against last before incrementing keeps 8'hFF from wrapping.
        if (!fifo_full) begin
          if (cur_q == last_q) begin
            state_d = FINISH;
          end else begin
            cur_d   = cur_q + 8'd1;
            state_d = ISSUE;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    rd_start    = (state_q == ISSUE);
    dump_done   = (state_q == FINISH);
    rd_addr     = cur_q;
    timeout_err = timeout_err_q;
    range_err   = range_err_q;
    out_valid   = !fifo_empty;
    out_addr    = mem_q[rd_ptr_q][15:8];
    out_data    = mem_q[rd_ptr_q][7:0];
  end

endmodule
